// File: rtl/capture_packer.sv
// Packs a captured RGB555 pixel stream into 961-byte line-pair packets (header + 960 pixel bytes)
// and buffers them in a byte FIFO drained by the downstream transmitter. Only whole packets are admitted.
module capture_packer #(
    parameter int LINE_W = 240,
    parameter int LINES  = 160,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       pix_data,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] Rnum,
    output logic              frame_done,
    output logic [15:0]       drop_cnt,
    output logic              sync_err
);

    localparam int PKT_BYTES = 1 + 4 * LINE_W;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int X_W       = $clog2(LINE_W);

    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   PKT_LEN   = (ADDR_W + 1)'(PKT_BYTES);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(LINE_W - 1);
    localparam logic [7:0]        PAIR_LAST = 8'(LINES / 2 - 1);

    typedef enum logic [2:0] {
        S_WAIT_SOF,
        S_HEADER,
        S_PIX_HI,
        S_PIX_LO,
        S_DROP
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [ADDR_W:0] free_space(input logic [ADDR_W-1:0] cnt);
        return CNT_MAX - {1'b0, cnt};
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [X_W-1:0]      r_x;
    logic                r_row;
    logic [7:0]          r_pair;
    logic                r_first;
    logic [7:0]          r_lo;
    logic                r_frame_done;
    logic [15:0]         r_drop_cnt;
    logic                r_sync_err;

    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_count;
    logic [7:0]          r_rd_data;

    logic                w_ready;
    logic                w_acc;
    logic                w_wr_en;
    logic [7:0]          w_wr_data;
    logic                w_rd_do;
    logic                w_adv;
    logic                w_start;
    logic                w_drop;
    logic                w_eol;
    logic                w_eop;
    logic                w_last_pair;

    assign w_eol       = (r_x == X_LAST);
    assign w_eop       = w_eol && r_row;
    assign w_last_pair = (r_pair == PAIR_LAST);
    assign w_rd_do     = rd_en && (r_count != '0);

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign pix_ready = w_ready && rst_n;
    assign w_acc     = pix_valid && pix_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = 8'h00;
        w_adv       = 1'b0;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_WAIT_SOF: begin
                // The SOF pixel stays on the bus and is taken later in PIX_HI or DROP.
                w_ready = !pix_sof;
                if (pix_valid && pix_sof) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                if (free_space(r_count) >= PKT_LEN) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = {1'b0, r_pair[6:0]};
                    w_state_nxt = S_PIX_HI;
                end else begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_PIX_HI: begin
                w_ready = 1'b1;
                if (pix_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = pix_data[15:8] & 8'h7F;
                    w_state_nxt = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                w_wr_en   = 1'b1;
                w_wr_data = r_lo;
                w_adv     = 1'b1;
                if (w_eop) begin
                    w_state_nxt = w_last_pair ? S_WAIT_SOF : S_HEADER;
                end else begin
                    w_state_nxt = S_PIX_HI;
                end
            end
            S_DROP: begin
                w_ready = 1'b1;
                if (pix_valid) begin
                    w_adv = 1'b1;
                    if (w_eop) begin
                        w_state_nxt = w_last_pair ? S_WAIT_SOF : S_HEADER;
                    end
                end
            end
            default: w_state_nxt = S_WAIT_SOF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_SOF;
            r_x          <= '0;
            r_row        <= 1'b0;
            r_pair       <= 8'h00;
            r_first      <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_cnt   <= 16'h0000;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_adv && w_eop && w_last_pair;
            if (w_start) begin
                r_x     <= '0;
                r_row   <= 1'b0;
                r_pair  <= 8'h00;
                r_first <= 1'b1;
            end else begin
                if (w_acc) begin
                    r_first <= 1'b0;
                end
                if (w_adv) begin
                    if (w_eol) begin
                        r_x   <= '0;
                        r_row <= ~r_row;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                    if (w_eop) begin
                        r_pair <= r_pair + 8'd1;
                    end
                end
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end
            // Only the very first pixel of a frame may legitimately carry SOF.
            if (w_acc && pix_sof && !r_first && (r_state != S_WAIT_SOF)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == S_PIX_HI) && pix_valid) begin
            r_lo <= pix_data[7:0];
        end
    end

    // Byte FIFO
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= 8'h00;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_do) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_en, w_rd_do})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_wr_en && ({1'b0, r_count} == CNT_MAX)));
        end
    end

    assign rd_data    = r_rd_data;
    assign Rnum       = r_count;
    assign frame_done = r_frame_done;
    assign drop_cnt   = r_drop_cnt;
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_capture_packer.sv
// Directed bench for capture_packer: packet layout, admission/drop, FIFO edge cases, SOF handling, reset.
module tb_capture_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic        pix_ready;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic [10:0] Rnum;
    logic        frame_done;
    logic [15:0] drop_cnt;
    logic        sync_err;

    int total = 0;
    int bad = 0;
    int rd_idx = 0;
    int fd_cnt = 0;
    bit pend = 1'b0;
    bit stuck = 1'b0;

    capture_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .Rnum       (Rnum),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    // Expected byte i of the packet stream when pixel n carries 16'h8000|n.
    function automatic logic [7:0] exp_byte(input int i);
        int k;
        int j;
        int n;
        k = i / 961;
        j = i % 961;
        if (j == 0) return 8'(k);
        n = k * 480 + (j - 1) / 2;
        if (((j - 1) % 2) == 0) return 8'((n >> 8) & 127);
        return 8'(n & 255);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) pend = rd_en && rst_n && (Rnum != 11'd0);

    always @(negedge clk) begin
        if (pend) begin
            chk($sformatf("rd_byte%0d", rd_idx), {24'h0, rd_data}, {24'h0, exp_byte(rd_idx)});
            rd_idx++;
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic send_pix(input logic [15:0] d, input bit sof);
        int guard;
        bit rdy;
        guard = 0;
        pix_data = d;
        pix_sof = sof;
        pix_valid = 1'b1;
        forever begin
            #1;
            rdy = pix_ready;
            @(negedge clk);
            if (rdy) break;
            guard++;
            assert (guard <= 8)
            else begin
                total++;
                bad++;
                stuck = 1'b1;
                $error("FAIL send_pix_timeout observed=stalled expected=accepted");
                break;
            end
        end
    endtask

    task automatic send_range(input int n0, input int n1, input int sof_n);
        for (int n = n0; n < n1 && !stuck; n++) begin
            send_pix(16'h8000 | 16'(n), n == sof_n);
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rnum", 32'(Rnum), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_sync_err", 32'(sync_err), 32'd0);
        rst_n = 1'b1;

        // Pixels before any SOF are consumed and dropped.
        pix_data = 16'h1234;
        pix_sof = 1'b0;
        pix_valid = 1'b1;
        #1;
        chk("presof_ready", 32'(pix_ready), 32'd1);
        @(negedge clk);
        repeat (3) send_pix(16'h4321, 1'b0);
        pix_valid = 1'b0;
        @(negedge clk);
        chk("presof_rnum", 32'(Rnum), 32'd0);

        // Build Rnum=5, then read and write in the same cycle.
        rd_idx = 0;
        send_range(0, 2, 0);
        chk("rw_rnum4", 32'(Rnum), 32'd4);
        @(negedge clk);
        chk("rw_rnum5", 32'(Rnum), 32'd5);
        rd_en = 1'b1;
        pix_data = 16'h8002;
        pix_sof = 1'b0;
        pix_valid = 1'b1;
        @(negedge clk);
        chk("rw_same_cycle", 32'(Rnum), 32'd5);
        rd_en = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        chk("rw_after_lo", 32'(Rnum), 32'd6);
        chk("rw_rd_count", 32'(rd_idx), 32'd1);

        // Reset mid-packet discards buffered bytes.
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rnum", 32'(Rnum), 32'd0);
        chk("midrst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Full frame, no reads: two packets fit, the remaining 78 drop.
        fd_cnt = 0;
        send_range(0, 960, 0);
        @(negedge clk);
        chk("two_pkts_rnum", 32'(Rnum), 32'd1922);
        chk("two_pkts_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        chk("third_hdr_drop", 32'(drop_cnt), 32'd1);
        send_range(960, 38400, -1);
        repeat (3) @(negedge clk);
        chk("frame_done_once", 32'(fd_cnt), 32'd1);
        chk("frame_drop_cnt", 32'(drop_cnt), 32'd78);
        chk("frame_rnum", 32'(Rnum), 32'd1922);
        chk("frame_sync_err", 32'(sync_err), 32'd0);

        // Drain both packets, then keep reading an empty FIFO.
        rd_idx = 0;
        rd_en = 1'b1;
        repeat (1930) @(negedge clk);
        chk("drain_count", 32'(rd_idx), 32'd1922);
        chk("empty_rnum", 32'(Rnum), 32'd0);
        chk("empty_rd_hold", 32'(rd_data), 32'hBF);
        rd_en = 1'b0;

        // Streaming frame with reads always on; stray SOF at pair 3 pixel 100.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_idx = 0;
        rd_en = 1'b1;
        send_range(0, 1540, 0);
        @(negedge clk);
        chk("sof_first_ok", 32'(sync_err), 32'd0);
        send_range(1540, 4800, 1540);
        repeat (6) @(negedge clk);
        chk("stream_rd_count", 32'(rd_idx), 32'd9611);
        chk("stream_rnum", 32'(Rnum), 32'd0);
        chk("stream_drop", 32'(drop_cnt), 32'd0);
        chk("stream_sync_err", 32'(sync_err), 32'd1);

        // Reset while in PIX_LO of pair 10.
        send_range(4800, 4805, -1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pair10_rst_rnum", 32'(Rnum), 32'd0);
        chk("pair10_rst_drop", 32'(drop_cnt), 32'd0);
        chk("pair10_rst_sync", 32'(sync_err), 32'd0);
        rst_n = 1'b1;
        rd_idx = 0;
        #1;
        chk("wait_sof_ready", 32'(pix_ready), 32'd1);
        pix_data = 16'h8000;
        pix_sof = 1'b1;
        pix_valid = 1'b1;
        #1;
        chk("wait_sof_hold", 32'(pix_ready), 32'd0);
        @(negedge clk);
        send_range(0, 3, 0);
        repeat (5) @(negedge clk);
        chk("restart_rd_count", 32'(rd_idx), 32'd7);
        chk("restart_rnum", 32'(Rnum), 32'd0);
        chk("restart_sync", 32'(sync_err), 32'd0);
        rd_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_packer.md
Name: capture_packer

Overview:
- Sits directly upstream of the UDP/GMII transmit stage and is the byte source its rd_data/rd_en/Rnum read port drains.
- Accepts the captured GBA RGB555 pixel stream and packs every two scan lines into one 961-byte packet: 1 header byte holding the line-pair index, then 960 pixel bytes.
- Stores the packets in an internal byte FIFO.
- Admits a packet only if the whole packet fits, so every packet in the FIFO is complete and packet boundaries never slip.

Parameters:
- LINE_W, 240, pixels per line
- LINES, 160, lines per frame; must be even
- ADDR_W, 11, FIFO address width; usable depth is 2^ADDR_W-1 = 2047 bytes
- PKT_BYTES, 1+4*LINE_W (961), bytes per packet; derived, must equal the downstream DATA_SIZE

Ports:
- clk  in  1  single clock for both write and read sides
- rst_n  in  1  synchronous active-low reset
- pix_data  in  16  RGB555 pixel; bit15 ignored and written as 0
- pix_valid  in  1  pixel present on pix_data
- pix_sof  in  1  qualifies the first pixel of a frame
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
- rd_en  in  1  pop one byte
- rd_data  out  8  popped byte, valid the cycle after rd_en
- Rnum  out  ADDR_W  bytes currently stored
- frame_done  out  1  one-cycle pulse after the last byte of pair LINES/2-1 is handled
- drop_cnt  out  16  count of dropped packets; saturating
- sync_err  out  1  sticky; set when pix_sof is seen outside WAIT_SOF

Behaviour:
- Reset (rst_n=0 at posedge clk): FIFO empties, Rnum=0, rd_data=0, pix_ready=0, frame_done=0, drop_cnt=0, sync_err=0, state=WAIT_SOF, x=0, pair=0.
- Reset mid-packet discards all buffered data.
- FIFO:
  - count=Rnum; full at 2047.
  - Write and read on the same cycle leave count unchanged.
  - rd_en when empty is ignored: count stays 0, rd_data holds.
  - Read latency is 1 cycle.
  - Pointers wrap modulo 2^ADDR_W.
- State machine:
  - WAIT_SOF: pix_ready=!pix_sof. Non-SOF pixels are consumed and discarded. When pix_valid&&pix_sof, the SOF pixel is left on the bus; go to HEADER with pair=0, x=0, row=0.
  - HEADER: pix_ready=0. Free space is 2047-Rnum, using the registered count (conservative).
    - If free>=PKT_BYTES: write byte {1'b0,pair[6:0]}, go to PIX_HI.
    - Else: drop_cnt+1 (saturates at 16'hFFFF), go to DROP.
  - PIX_HI: pix_ready=1. On accept, write pix_data[15:8]&8'h7F, latch pix_data[7:0], go to PIX_LO.
  - PIX_LO: pix_ready=0. Write the latched low byte, then advance x/row. Exit follows the end-of-pair rule; otherwise return to PIX_HI.
  - DROP: pix_ready=1. Each accepted pixel advances x/row with no FIFO write. Exit follows the end-of-pair rule.
  - End-of-pair rule (PIX_LO and DROP): x wraps at LINE_W-1 and toggles row. At x=LINE_W-1 with row=1, increment pair. If pair was LINES/2-1, pulse frame_done and go to WAIT_SOF; else go to HEADER.
- Throughput and width:
  - Maximum input rate is 1 pixel per 2 cycles; the header costs 1 extra stall cycle per packet.
  - Writes never occur while full: admission guarantees this, and an assertion covers it.
- pix_sof outside WAIT_SOF: ignored (pixel processed normally), sync_err<=1.
- pix_sof accepted in PIX_HI still writes that pixel.

Test Plan:
- Reset, then one frame at 1 pixel per 2 cycles with no reads -> after 2 packets Rnum=1922; byte0=0x00, byte961=0x01; the third header attempt drops (free=125); frame_done pulses once, drop_cnt=78.
- Frame with rd_en continuously high, pixel n=y*240+x carrying 16'h8000|n -> 80 packets read. Each packet is header k followed by alternating hi/lo bytes; bit15 is stripped, e.g. pixel 0x8105 yields 0x01,0x05; drop_cnt=0, Rnum returns to 0.
- pix_valid with pix_sof=0 before the first SOF -> pix_ready=1, no writes; Rnum stays 0 until SOF; the first written byte is header 0x00.
- pix_sof pulsed at pixel 100 of pair 3 -> sync_err=1, stream continues; pair index 4 appears at the next header.
- rd_en on an empty FIFO, plus simultaneous read/write at Rnum=5 -> Rnum stays 0, then stays 5; rd_data is unchanged after the empty read.
- rst_n low during PIX_LO of pair 10 -> next cycle Rnum=0, state WAIT_SOF, drop_cnt=0; the next SOF frame restarts with header 0x00.
